// File: rtl/RV32I_defines.sv
// RV32I base encodings shared across the core: major opcodes and the operand word type.
package RV32I_defines;

    typedef logic [31:0] RV32I_OPERAND_t;

    typedef enum logic [6:0] {
        R_TYPE      = 7'b0110011,
        I_TYPE      = 7'b0010011,
        I_LOAD_TYPE = 7'b0000011,
        I_JALR_TYPE = 7'b1100111,
        I_SYS_TYPE  = 7'b1110011,
        S_TYPE      = 7'b0100011,
        B_TYPE      = 7'b1100011,
        U_LUI_TYPE  = 7'b0110111,
        U_AUIPC_TYPE = 7'b0010111,
        J_TYPE      = 7'b1101111
    } RV32I_OPCODE_t;

endpackage

// File: rtl/fetch_pc_sequencer_pkg.sv
// Fetch-stage types: sequencer state encoding and the sequential PC step.
package fe_pkg;
  import RV32I_defines::*;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t IDLE = 2'd0;
  localparam fetch_state_t REQ  = 2'd1;
  localparam fetch_state_t HOLD = 2'd2;
  localparam fetch_state_t HALT = 2'd3;

  localparam RV32I_OPERAND_t PC_STEP = 32'd4;

  // Sequential successor; wraps modulo 2^32 by construction.
  function automatic RV32I_OPERAND_t pc_next(input RV32I_OPERAND_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// Bundle of the fetch sequencer's imem, decode and execute-feedback signals.
interface fetch_pc_sequencer_if;
  import RV32I_defines::*;

  logic            imem_req;
  RV32I_OPERAND_t  imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  logic            instr_valid;
  logic [31:0]     instr;
  RV32I_OPERAND_t  instr_pc;
  logic            instr_ready;

  logic            ex_valid;
  RV32I_OPCODE_t   ex_opcode;
  logic            ex_cond_jump;
  RV32I_OPERAND_t  ex_target;

  logic            flush;
  logic            misaligned_fault;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, flush, misaligned_fault,
    input  imem_ack, imem_rdata, instr_ready, ex_valid, ex_opcode, ex_cond_jump, ex_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, flush, misaligned_fault,
    output imem_ack, imem_rdata, instr_ready, ex_valid, ex_opcode, ex_cond_jump, ex_target
  );

endinterface

// File: rtl/fetch_pc_sequencer_redirect_decode.sv
// Combinational redirect decision from the execute stage, plus target alignment check.
module fetch_redirect_decode
  import RV32I_defines::*;
(
  input  logic           ex_valid,
  input  RV32I_OPCODE_t  ex_opcode,
  input  logic           ex_cond_jump,
  input  RV32I_OPERAND_t ex_target,
  output logic           redirect,
  output logic           misaligned
);

  logic taken_branch;
  logic jump;

  assign taken_branch = (ex_opcode == B_TYPE) && ex_cond_jump;
  assign jump         = (ex_opcode == J_TYPE) || (ex_opcode == I_JALR_TYPE);
  assign redirect     = ex_valid && (taken_branch || jump);
  assign misaligned   = redirect && (ex_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: sequences imem requests, buffers one instruction for decode, squashes on redirect.
module fetch_pc_sequencer
  import RV32I_defines::*;
  import fe_pkg::*;
#(
  parameter RV32I_OPERAND_t RESET_PC = 32'h0040_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_pc_sequencer_if.master bus
);

  fetch_state_t   state_q, state_d;
  RV32I_OPERAND_t pc_q, pc_d;
  RV32I_OPERAND_t pc_pending_q, pc_pending_d;
  logic           discard_q, discard_d;
  logic [31:0]    instr_q, instr_d;
  RV32I_OPERAND_t instr_pc_q, instr_pc_d;
  logic           flush_q, flush_d;
  logic           fault_q, fault_d;

  logic redirect;
  logic misaligned;

  fetch_redirect_decode u_redirect_decode (
    .ex_valid     (bus.ex_valid),
    .ex_opcode    (bus.ex_opcode),
    .ex_cond_jump (bus.ex_cond_jump),
    .ex_target    (bus.ex_target),
    .redirect     (redirect),
    .misaligned   (misaligned)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_pending_d = pc_pending_q;
    discard_d    = discard_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    fault_d      = fault_q;
    flush_d      = redirect && (state_q != HALT);

    if ((state_q != HALT) && misaligned) begin
      state_d = HALT;
      fault_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            pc_d = bus.ex_target;
          end
          state_d = REQ;
        end
        REQ: begin
          // The address must stay stable until ack, so a redirect without ack is parked.
          if (redirect) begin
            if (bus.imem_ack) begin
              pc_d      = bus.ex_target;
              discard_d = 1'b0;
            end else begin
              discard_d    = 1'b1;
              pc_pending_d = bus.ex_target;
            end
          end else if (bus.imem_ack) begin
            if (discard_q) begin
              pc_d      = pc_pending_q;
              discard_d = 1'b0;
            end else begin
              instr_d    = bus.imem_rdata;
              instr_pc_d = pc_q;
              pc_d       = pc_next(pc_q);
              state_d    = HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_d    = bus.ex_target;
            state_d = REQ;
          end else if (bus.instr_ready) begin
            state_d = REQ;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pc_pending_q <= RESET_PC;
      discard_q    <= 1'b0;
      instr_q      <= 32'd0;
      instr_pc_q   <= 32'd0;
      flush_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_pending_q <= pc_pending_d;
      discard_q    <= discard_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      flush_q      <= flush_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.imem_req         = (state_q == REQ);
  assign bus.imem_addr        = pc_q;
  assign bus.instr_valid      = (state_q == HOLD);
  assign bus.instr            = instr_q;
  assign bus.instr_pc         = instr_pc_q;
  assign bus.flush            = flush_q;
  assign bus.misaligned_fault = fault_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed vector bench for fetch_pc_sequencer: outputs checked at negedge, inputs then driven.
module tb_fetch_pc_sequencer;
  import RV32I_defines::*;

  localparam logic [31:0] R   = 32'h0040_0000;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic clk;
  logic rst_n;
  fetch_pc_sequencer_if bus ();

  fetch_pc_sequencer #(.RESET_PC(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ack;
    logic [31:0]   rdata;
    logic          rdy;
    logic          exv;
    RV32I_OPCODE_t op;
    logic          cond;
    logic [31:0]   tgt;
    logic          e_req;
    logic [31:0]   e_addr;
    logic          e_val;
    logic [31:0]   e_instr;
    logic [31:0]   e_ipc;
    logic          e_flush;
    logic          e_fault;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t v(input logic ack, input logic [31:0] rdata, input logic rdy,
                             input logic exv, input RV32I_OPCODE_t op, input logic cond,
                             input logic [31:0] tgt, input logic req, input logic [31:0] addr,
                             input logic val, input logic [31:0] ins, input logic [31:0] ipc,
                             input logic fl, input logic fa);
    vec_t r;
    r.ack = ack; r.rdata = rdata; r.rdy = rdy; r.exv = exv; r.op = op; r.cond = cond; r.tgt = tgt;
    r.e_req = req; r.e_addr = addr; r.e_val = val; r.e_instr = ins; r.e_ipc = ipc;
    r.e_flush = fl; r.e_fault = fa;
    return r;
  endfunction

  task automatic check(input string name, input logic req, input logic [31:0] addr,
                       input logic val, input logic [31:0] ins, input logic [31:0] ipc,
                       input logic fl, input logic fa);
    logic [99:0] act, exp;
    act = {bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc,
           bus.flush, bus.misaligned_fault};
    exp = {req, addr, val, ins, ipc, fl, fa};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got req=%0b addr=%h val=%0b instr=%h ipc=%h flush=%0b fault=%0b want req=%0b addr=%h val=%0b instr=%h ipc=%h flush=%0b fault=%0b",
               name, bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc,
               bus.flush, bus.misaligned_fault, req, addr, val, ins, ipc, fl, fa);
    end else begin
      $display("ok   %s: req=%0b addr=%h val=%0b instr=%h ipc=%h flush=%0b fault=%0b",
               name, req, addr, val, ins, ipc, fl, fa);
    end
  endtask

  task automatic drive_idle();
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.instr_ready = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_opcode = I_TYPE; bus.ex_cond_jump = 1'b0; bus.ex_target = 32'd0;
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;

    // Sequential fetch, backpressure, branches, discard-on-redirect, wrap, misaligned halt.
    vecs.push_back(v(0, 0,            0, 0, I_TYPE,      0, 0,            0, R,            0, 0,            0,            0, 0));
    vecs.push_back(v(1, 32'hA000_0000,1, 0, I_TYPE,      0, 0,            1, R,            0, 0,            0,            0, 0));
    vecs.push_back(v(0, 0,            1, 0, I_TYPE,      0, 0,            0, R+4,          1, 32'hA000_0000,R,            0, 0));
    vecs.push_back(v(1, 32'hA000_0001,1, 0, I_TYPE,      0, 0,            1, R+4,          0, 32'hA000_0000,R,            0, 0));
    vecs.push_back(v(0, 0,            1, 0, I_TYPE,      0, 0,            0, R+8,          1, 32'hA000_0001,R+4,          0, 0));
    vecs.push_back(v(1, 32'hA000_0002,0, 0, I_TYPE,      0, 0,            1, R+8,          0, 32'hA000_0001,R+4,          0, 0));
    vecs.push_back(v(0, 0,            0, 0, I_TYPE,      0, 0,            0, R+12,         1, 32'hA000_0002,R+8,          0, 0));
    vecs.push_back(v(0, 0,            0, 0, I_TYPE,      0, 0,            0, R+12,         1, 32'hA000_0002,R+8,          0, 0));
    vecs.push_back(v(0, 0,            1, 0, I_TYPE,      0, 0,            0, R+12,         1, 32'hA000_0002,R+8,          0, 0));
    vecs.push_back(v(1, 32'hA000_0003,0, 0, I_TYPE,      0, 0,            1, R+12,         0, 32'hA000_0002,R+8,          0, 0));
    vecs.push_back(v(0, 0,            0, 1, B_TYPE,      0, R+32'h100,    0, R+16,         1, 32'hA000_0003,R+12,         0, 0));
    vecs.push_back(v(0, 0,            1, 1, B_TYPE,      1, R+32'h100,    0, R+16,         1, 32'hA000_0003,R+12,         0, 0));
    vecs.push_back(v(0, 0,            0, 1, I_JALR_TYPE, 0, R+32'h200,    1, R+32'h100,    0, 32'hA000_0003,R+12,         1, 0));
    vecs.push_back(v(0, 0,            0, 0, I_TYPE,      0, 0,            1, R+32'h100,    0, 32'hA000_0003,R+12,         1, 0));
    vecs.push_back(v(0, 0,            0, 1, I_JALR_TYPE, 0, R+32'h300,    1, R+32'h100,    0, 32'hA000_0003,R+12,         0, 0));
    vecs.push_back(v(1, BAD,          1, 0, I_TYPE,      0, 0,            1, R+32'h100,    0, 32'hA000_0003,R+12,         1, 0));
    vecs.push_back(v(1, 32'hA000_0004,1, 0, I_TYPE,      0, 0,            1, R+32'h300,    0, 32'hA000_0003,R+12,         0, 0));
    vecs.push_back(v(0, 0,            1, 0, I_TYPE,      0, 0,            0, R+32'h304,    1, 32'hA000_0004,R+32'h300,    0, 0));
    vecs.push_back(v(1, BAD,          1, 1, J_TYPE,      0, R+32'h400,    1, R+32'h304,    0, 32'hA000_0004,R+32'h300,    0, 0));
    vecs.push_back(v(1, 32'hA000_0005,0, 1, R_TYPE,      1, R+32'h800,    1, R+32'h400,    0, 32'hA000_0004,R+32'h300,    1, 0));
    vecs.push_back(v(0, 0,            0, 1, I_JALR_TYPE, 0, 32'hFFFF_FFFC,0, R+32'h404,    1, 32'hA000_0005,R+32'h400,    0, 0));
    vecs.push_back(v(1, 32'hA000_0006,1, 0, I_TYPE,      0, 0,            1, 32'hFFFF_FFFC,0, 32'hA000_0005,R+32'h400,    1, 0));
    vecs.push_back(v(0, 0,            1, 0, I_TYPE,      0, 0,            0, 32'h0,        1, 32'hA000_0006,32'hFFFF_FFFC,0, 0));
    vecs.push_back(v(1, BAD,          1, 1, J_TYPE,      0, R+32'h102,    1, 32'h0,        0, 32'hA000_0006,32'hFFFF_FFFC,0, 0));
    vecs.push_back(v(1, BAD,          1, 1, J_TYPE,      0, R+32'h500,    0, 32'h0,        0, 32'hA000_0006,32'hFFFF_FFFC,1, 1));
    vecs.push_back(v(0, 0,            0, 0, I_TYPE,      0, 0,            0, 32'h0,        0, 32'hA000_0006,32'hFFFF_FFFC,0, 1));
    vecs.push_back(v(0, 0,            0, 0, I_TYPE,      0, 0,            0, 32'h0,        0, 32'hA000_0006,32'hFFFF_FFFC,0, 1));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_val,
            vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_flush, vecs[i].e_fault);
      bus.imem_ack = vecs[i].ack; bus.imem_rdata = vecs[i].rdata; bus.instr_ready = vecs[i].rdy;
      bus.ex_valid = vecs[i].exv; bus.ex_opcode = vecs[i].op; bus.ex_cond_jump = vecs[i].cond;
      bus.ex_target = vecs[i].tgt;
      @(negedge clk);
    end

    // Reset pulse clears the sticky fault and restarts at RESET_PC.
    drive_idle();
    rst_n = 1'b0;
    #1;
    check("halt_reset", 0, R, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("idle_after_reset", 0, R, 0, 0, 0, 0, 0);
    bus.imem_ack = 1'b1; bus.imem_rdata = BAD;
    @(negedge clk);
    check("late_ack_ignored", 1, R, 0, 0, 0, 0, 0);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    check("req_waits_ack", 1, R, 0, 0, 0, 0, 0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA000_0007; bus.instr_ready = 1'b1;
    @(negedge clk);
    check("restart_fetch", 0, R+4, 1, 32'hA000_0007, R, 0, 0);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    check("next_req", 1, R+4, 0, 32'hA000_0007, R, 0, 0);

    // Asynchronous reset in the middle of an outstanding request.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_fetch", 0, R, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_sequencer.md
# fetch_pc_sequencer

Fetch-stage controller that owns the program counter and sequences instruction fetch over a request/acknowledge instruction-memory port. Decides each cycle whether the next PC is PC+4 or a redirect target resolved in execute (taken branch, JAL, JALR). Buffers one fetched instruction toward decode under backpressure. Squashes wrong-path fetches on redirect and traps misaligned targets. Sits between instruction memory and decode in the `fe` hierarchy.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request. Held with stable `imem_addr` until `imem_ack`.
- `imem_addr`  out  32 (`RV32I_OPERAND_t`)  fetch address, equal to the current PC.
- `imem_ack`  in  1  response valid this cycle. Only meaningful while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `instr_valid`  out  1  buffered instruction available to decode.
- `instr`  out  32  buffered instruction word.
- `instr_pc`  out  32  PC of `instr`.
- `instr_ready`  in  1  decode accepts `instr` when `instr_valid`&&`instr_ready`.
- `ex_valid`  in  1  execute stage holds a valid instruction.
- `ex_opcode`  in  `RV32I_OPCODE_t`  opcode of the execute-stage instruction.
- `ex_cond_jump`  in  1  branch-condition result from execute.
- `ex_target`  in  32 (`RV32I_OPERAND_t`)  ALU-computed target.
- `flush`  out  1  one-cycle pulse. Decode/execute drop their contents.
- `misaligned_fault`  out  1  sticky. Set when a taken target has [1:0]≠0.

## Operation
- Redirect is taken when `ex_valid` and either of these holds:
  - (`ex_opcode`==B_TYPE and `ex_cond_jump`)
  - `ex_opcode` ∈ {J_TYPE, I_JALR_TYPE}
- All other opcodes advance sequentially.
- State register is of type `fetch_state_t`. States:
  - IDLE: `imem_req`=0. Always moves to REQ next cycle. A redirect here loads `pc`←`ex_target`.
  - REQ: `imem_req`=1, `imem_addr`=`pc`.
    - On `imem_ack` with no discard pending and no redirect: capture `imem_rdata`/`pc` into the buffer, `pc`←`pc`+4 (mod 2^32, wraps FFFF_FFFC→0000_0000), go to HOLD.
    - Redirect with no `imem_ack`: address stays stable, set `discard`, latch target into `pc_pending`.
    - Redirect with `imem_ack` in the same cycle: drop the response, `pc`←`ex_target`, stay REQ.
    - On `imem_ack` while `discard` is set: drop the response, `pc`←`pc_pending`, clear `discard`, stay REQ.
    - A later redirect while `discard` is set overwrites `pc_pending` (newest wins).
  - HOLD: `instr_valid`=1.
    - `instr_ready` moves to REQ.
    - A redirect invalidates the buffer (no handshake counted even if `instr_ready`=1), `pc`←`ex_target`, go to REQ.
  - HALT: entered from any state when a redirect target has [1:0]≠0.
    - Sets `misaligned_fault`. `imem_req`=0, `instr_valid`=0.
    - Stays until reset. Any in-flight `imem_ack` is ignored.
- `flush`: registered, asserted the cycle after any accepted redirect, including the one that enters HALT.
- Redirect has priority over the decode handshake and over a sequential advance.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `instr_pc`=0, `flush`=0, `misaligned_fault`=0, state IDLE, `discard`=0.
- First `imem_req` in cycle 1 after `rst_n` deasserts.
- With zero-wait memory (ack in the request cycle), latency is 1: `instr_valid` rises the cycle after `imem_ack`.
- Peak throughput is one instruction per 2 cycles (REQ, HOLD).
- Redirect to new `imem_addr`:
  - From HOLD: `imem_addr` = target on the next cycle.
  - From REQ: `imem_addr` = target on the cycle after the pending ack.
- Reset asserted mid-fetch drops all state immediately. A late `imem_ack` after reset release, seen in IDLE, is ignored.

## Structure
- `fe_pkg` gains `fetch_state_t` (IDLE, REQ, HOLD, HALT) and `PC_STEP`=4.
- Opcode encodings and `RV32I_OPERAND_t` come from `RV32I_defines.sv`.
- One combinational sub-module, `fetch_redirect_decode`:
  - Inputs: `ex_valid`, `ex_opcode`, `ex_cond_jump`, `ex_target`.
  - Outputs: `redirect`, `misaligned`.
- The PC register, buffer, discard flag and FSM stay in the top module.

## Test plan
- Reset, zero-wait memory, `instr_ready`=1 → `imem_addr` sequence 0x0040_0000, 0x0040_0004, 0x0040_0008 on every other cycle. `instr_pc` matches.
- HOLD with `instr_ready`=0 for 3 cycles → `instr`/`instr_pc` stable, `imem_req`=0. Release → next addr = `pc`+4.
- Taken B_TYPE, target 0x0040_0100, in HOLD → `instr_valid` drops, `flush` pulses 1 cycle, next `imem_addr`=0x0040_0100. Same with `ex_cond_jump`=0 → no redirect.
- JALR, target 0x0040_0200, in REQ with ack delayed 2 cycles → `imem_addr` holds the old PC until ack. Response discarded (no `instr_valid`). Then addr=0x0040_0200. A second redirect to 0x0040_0300 before the ack → addr=0x0040_0300.
- J_TYPE, target 0x0040_0102 → `misaligned_fault`=1, `imem_req`=0 forever. `rst_n` pulse clears it and restarts at `RESET_PC`.
- PC at 0xFFFF_FFFC, sequential fetch → next `imem_addr`=0x0000_0000.
